sc_chain_loader: RTL

- Configuration-chain driver that sits directly upstream of the sc_dff scan chain.
- Accepts configuration words over a valid/ready handshake and serialises them LSB-first onto the chain head, one bit per enabled cycle, until CHAIN_LEN bits are shifted.
- Captures the bits falling out of the chain tail and repacks them into readback words, so the previous chain contents can be checked.

---
 rtl/sc_chain_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sc_chain_loader.sv
// Configuration-chain driver: serialises handshaked words LSB-first onto the
// sc_dff chain head and repacks the bits leaving the chain tail into readback words.
module sc_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              sc_head,
  output logic              sc_shift_en,
  input  logic              sc_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int PI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [PI_W-1:0]  PI_TOP = PI_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [WORD_W-1:0] word_buf;
  logic [BC_W-1:0]   buf_cnt;
  logic [CNT_W-1:0]  bits_issued;
  logic [CNT_W-1:0]  remaining;
  logic [BC_W-1:0]   take_n;
  logic [WORD_W-1:0] packer;
  logic [WORD_W-1:0] packed_next;
  logic [PI_W-1:0]   pack_idx;
  logic              accept;
  logic              last_shift;
  logic              word_full;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cfg_ready   = 1'b0;
    sc_shift_en = 1'b0;
    sc_head     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    last_shift  = 1'b0;
    word_full   = 1'b0;
    remaining   = LEN_C - bits_issued;
    // The final word only contributes the bits still owed to the chain.
    take_n      = (remaining >= WORD_C) ? BC_W'(WORD_W) : BC_W'(remaining);
    packed_next = packer;
    packed_next[pack_idx] = sc_tail;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD;
      end
      S_LOAD: begin
        busy        = 1'b1;
        sc_shift_en = (buf_cnt != '0);
        sc_head     = sc_shift_en & word_buf[0];
        last_shift  = sc_shift_en && (bit_count == LAST_C);
        // buf_cnt==1 in LOAD means the last buffered bit leaves this cycle.
        cfg_ready   = (bits_issued != LEN_C) &&
                      ((buf_cnt == '0) || (buf_cnt == BC_W'(1)));
        accept      = cfg_ready & cfg_valid;
        word_full   = sc_shift_en && ((pack_idx == PI_TOP) || last_shift);
        if (last_shift) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_buf    <= '0;
      buf_cnt     <= '0;
      bits_issued <= '0;
      bit_count   <= '0;
      packer      <= '0;
      pack_idx    <= '0;
      rb_data     <= '0;
      rb_valid    <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == S_IDLE && start) begin
        word_buf    <= '0;
        buf_cnt     <= '0;
        bits_issued <= '0;
        bit_count   <= '0;
        packer      <= '0;
        pack_idx    <= '0;
      end
      if (sc_shift_en) begin
        word_buf  <= word_buf >> 1;
        buf_cnt   <= buf_cnt - BC_W'(1);
        bit_count <= bit_count + CNT_W'(1);
        if (word_full) begin
          rb_data  <= packed_next;
          rb_valid <= 1'b1;
          packer   <= '0;
          pack_idx <= '0;
        end else begin
          packer   <= packed_next;
          pack_idx <= pack_idx + PI_W'(1);
        end
      end
      // A refill on the last-bit cycle overrides the shift of the old word.
      if (accept) begin
        word_buf    <= cfg_data;
        buf_cnt     <= take_n;
        bits_issued <= bits_issued + CNT_W'(take_n);
      end
    end
  end

endmodule
